// File: rtl/rf_pkg.sv
// Shared definitions for the register-file write port: widths, port ids, one-hot helper.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package rf_pkg;

    localparam int RF_DW   = 32;
    localparam int RF_AW   = 5;
    localparam int RF_NREG = 2 ** RF_AW;

    // Writer identities as seen on wr_src and in the round-robin pointer.
    localparam logic P0 = 1'b0;
    localparam logic P1 = 1'b1;

    // One-hot register select, all-zero when en is low. Shared with the write decoder.
    function automatic logic [RF_NREG-1:0] onehot_reg(input logic [RF_AW-1:0] addr,
                                                      input logic             en);
        logic [RF_NREG-1:0] vec;
        vec       = '0;
        vec[addr] = en;
        return vec;
    endfunction

endpackage

// File: rtl/rf_wr_slot.sv
// One-entry holding register for a single register-file writer.
// Latency: loaded entry visible on the outputs one cycle after the load edge.
// Backpressure: none internally; the caller loads only when empty or draining this cycle.
module rf_wr_slot
    import rf_pkg::*;
#(
    parameter int DW = RF_DW,
    parameter int AW = RF_AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_i,
    input  logic          drain_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] data_i,
    output logic          full_o,
    output logic [AW-1:0] addr_o,
    output logic [DW-1:0] data_o,
    output logic          age_o
);

    logic          full_q, full_d;
    logic          age_q, age_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;

    // Next-state: a load wins over a drain (same-cycle refill). The age bit marks an
    // entry that has already lost one arbitration round, i.e. it is the older entry.
    always_comb begin
        full_d = full_q;
        age_d  = age_q;
        addr_d = addr_q;
        data_d = data_q;
        if (load_i) begin
            full_d = 1'b1;
            age_d  = 1'b0;
            addr_d = addr_i;
            data_d = data_i;
        end else if (drain_i) begin
            full_d = 1'b0;
            age_d  = 1'b0;
        end else if (full_q) begin
            age_d  = 1'b1;
        end
    end

    // Slot state register; reset discards any held entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            age_q  <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            age_q  <= age_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

    assign full_o = full_q;
    assign age_o  = age_q;
    assign addr_o = addr_q;
    assign data_o = data_q;

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the single register-file write port between pipeline write-back (P0) and multi-cycle unit (P1).
// Latency: accept at edge N, registered write visible after edge N+1; one write issued per cycle.
// Backpressure: pX_ready = slot empty or slot granted this cycle, independent of pX_valid.
module rf_write_arbiter
    import rf_pkg::*;
#(
    parameter int DW        = RF_DW,
    parameter int AW        = RF_AW,
    parameter bit ZERO_DROP = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_valid,
    output logic              p0_ready,
    input  logic [AW-1:0]     p0_addr,
    input  logic [DW-1:0]     p0_data,
    input  logic              p1_valid,
    output logic              p1_ready,
    input  logic [AW-1:0]     p1_addr,
    input  logic [DW-1:0]     p1_data,
    output logic              wr_en,
    output logic [AW-1:0]     wr_addr,
    output logic [DW-1:0]     wr_data,
    output logic              wr_src,
    output logic [2**AW-1:0]  pend_mask
);

    logic          s0_full, s1_full;
    logic          s0_age, s1_age;
    logic [AW-1:0] s0_addr, s1_addr;
    logic [DW-1:0] s0_data, s1_data;
    logic          s0_zero, s1_zero;

    logic          grant0, grant1, grant_any;
    logic          p0_load, p1_load;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_data;
    logic          sel_drop;

    logic          rr_q, rr_d;
    logic          wr_en_q, wr_en_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [DW-1:0] wr_data_q, wr_data_d;
    logic          wr_src_q, wr_src_d;

    // Slots are loaded only on a valid handshake, so idle address/data buses never leak.
    assign p0_ready = ~s0_full | grant0;
    assign p1_ready = ~s1_full | grant1;
    assign p0_load  = p0_valid & p0_ready;
    assign p1_load  = p1_valid & p1_ready;

    rf_wr_slot #(.DW(DW), .AW(AW)) u_slot0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (p0_load),
        .drain_i (grant0),
        .addr_i  (p0_addr),
        .data_i  (p0_data),
        .full_o  (s0_full),
        .addr_o  (s0_addr),
        .data_o  (s0_data),
        .age_o   (s0_age)
    );

    rf_wr_slot #(.DW(DW), .AW(AW)) u_slot1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (p1_load),
        .drain_i (grant1),
        .addr_i  (p1_addr),
        .data_i  (p1_data),
        .full_o  (s1_full),
        .addr_o  (s1_addr),
        .data_o  (s1_data),
        .age_o   (s1_age)
    );

    // Arbitration: lone full slot wins; otherwise the older entry (keeps same-register
    // writes in arrival order); a same-cycle tie goes to the port the pointer did not name.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (s0_full && !s1_full) begin
            grant0 = 1'b1;
        end else if (s1_full && !s0_full) begin
            grant1 = 1'b1;
        end else if (s0_full && s1_full) begin
            if (s0_age != s1_age) begin
                grant0 = s0_age;
                grant1 = s1_age;
            end else if (rr_q == P0) begin
                grant1 = 1'b1;
            end else begin
                grant0 = 1'b1;
            end
        end
    end

    assign grant_any = grant0 | grant1;
    assign sel_addr  = grant1 ? s1_addr : s0_addr;
    assign sel_data  = grant1 ? s1_data : s0_data;
    assign sel_drop  = ZERO_DROP && (sel_addr == '0);

    // Output-stage next state: a dropped register-0 write still drains but never enables.
    always_comb begin
        rr_d      = rr_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wr_src_d  = wr_src_q;
        if (grant_any) begin
            rr_d      = grant1 ? P1 : P0;
            wr_en_d   = ~sel_drop;
            wr_addr_d = sel_addr;
            wr_data_d = sel_data;
            wr_src_d  = grant1 ? P1 : P0;
        end
    end

    // Registered write port and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q      <= P0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_src_q  <= P0;
        end else begin
            rr_q      <= rr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            wr_src_q  <= wr_src_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign wr_src  = wr_src_q;

    // Register-0 entries that will be discarded never count as pending.
    assign s0_zero = ZERO_DROP && (s0_addr == '0);
    assign s1_zero = ZERO_DROP && (s1_addr == '0);

    assign pend_mask = onehot_reg(s0_addr, s0_full & ~s0_zero)
                     | onehot_reg(s1_addr, s1_full & ~s1_zero)
                     | onehot_reg(wr_addr_q, wr_en_q);

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: checks handshakes, write order, pend_mask and reset.
// Latency: n/a.
// Backpressure: n/a.
module tb_rf_write_arbiter;

    logic        clk;
    logic        rst_n;
    logic        p0_valid, p1_valid;
    logic        p0_ready, p1_ready;
    logic [4:0]  p0_addr, p1_addr;
    logic [31:0] p0_data, p1_data;
    logic        wr_en, wr_src;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [31:0] pend_mask;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        src;
        logic [4:0]  addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    wr_t wlog[$];
    int  cyc = 0;

    rf_write_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .p0_valid  (p0_valid),
        .p0_ready  (p0_ready),
        .p0_addr   (p0_addr),
        .p0_data   (p0_data),
        .p1_valid  (p1_valid),
        .p1_ready  (p1_ready),
        .p1_addr   (p1_addr),
        .p1_data   (p1_data),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_src    (wr_src),
        .pend_mask (pend_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every issued write, sampled on the falling edge.
    always @(negedge clk) begin
        wr_t e;
        cyc = cyc + 1;
        if (wr_en === 1'b1) begin
            e.src  = wr_src;
            e.addr = wr_addr;
            e.data = wr_data;
            e.cyc  = cyc;
            wlog.push_back(e);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pack_ent(input logic src, input logic [4:0] a, input logic [15:0] d);
        return {3'b000, src, 3'b000, a, 4'b0000, d};
    endfunction

    function automatic logic [31:0] ent(input int i);
        if (i < wlog.size())
            return pack_ent(wlog[i].src, wlog[i].addr, wlog[i].data[15:0]);
        return 32'hFFFF_FFFF;
    endfunction

    // Watchdog: the bench must always end.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n0, n1, k0, k1;
        int bad_cyc, bad_alt, bad_dat;
        logic hs0, hs1;

        rst_n    = 1'b0;
        p0_valid = 1'b0; p0_addr = '0; p0_data = '0;
        p1_valid = 1'b0; p1_addr = '0; p1_data = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_wr_en",   32'(wr_en),   32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", wr_data,      32'd0);
        chk("rst_wr_src",  32'(wr_src),  32'd0);
        chk("rst_pend",    pend_mask,    32'd0);
        chk("rst_p0_rdy",  32'(p0_ready), 32'd1);
        chk("rst_p1_rdy",  32'(p1_ready), 32'd1);
        tick();
        rst_n = 1'b1;
        tick();

        // 1: single P0 write r5=0xAA
        wlog.delete();
        p0_valid = 1'b1; p0_addr = 5'd5; p0_data = 32'h0000_00AA;
        #1;
        chk("t1_p0_rdy",  32'(p0_ready), 32'd1);
        chk("t1_pend_pre", pend_mask,    32'd0);
        tick();
        p0_valid = 1'b0; p0_addr = 5'd31; p0_data = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("t1_pend_slot", pend_mask,   32'h0000_0020);
        chk("t1_wr_en_n",   32'(wr_en),  32'd0);
        @(negedge clk);
        chk("t1_wr_en",     32'(wr_en),  32'd1);
        chk("t1_wr_addr",   32'(wr_addr), 32'd5);
        chk("t1_wr_data",   wr_data,     32'h0000_00AA);
        chk("t1_wr_src",    32'(wr_src), 32'd0);
        chk("t1_pend_wr",   pend_mask,   32'h0000_0020);
        @(negedge clk);
        chk("t1_wr_en_off", 32'(wr_en),  32'd0);
        chk("t1_pend_clr",  pend_mask,   32'd0);
        chk("t1_count",     32'(wlog.size()), 32'd1);

        // 2: simultaneous P0 r3=0x11 and P1 r4=0x22, pointer at P0 -> P1 first
        tick();
        wlog.delete();
        p0_valid = 1'b1; p0_addr = 5'd3; p0_data = 32'h11;
        p1_valid = 1'b1; p1_addr = 5'd4; p1_data = 32'h22;
        #1;
        chk("t2_p0_rdy", 32'(p0_ready), 32'd1);
        chk("t2_p1_rdy", 32'(p1_ready), 32'd1);
        tick();
        p0_valid = 1'b0; p1_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("t2_count", 32'(wlog.size()), 32'd2);
        chk("t2_first", ent(0), pack_ent(1'b1, 5'd4, 16'h22));
        chk("t2_second", ent(1), pack_ent(1'b0, 5'd3, 16'h11));

        // 3: P1 r7=1 then P0 r7=2 one cycle later -> arrival order kept
        tick();
        wlog.delete();
        p1_valid = 1'b1; p1_addr = 5'd7; p1_data = 32'h1;
        tick();
        p1_valid = 1'b0;
        p0_valid = 1'b1; p0_addr = 5'd7; p0_data = 32'h2;
        #1;
        chk("t3_p0_rdy", 32'(p0_ready), 32'd1);
        @(negedge clk);
        chk("t3_pend7_a", 32'(pend_mask[7]), 32'd1);
        tick();
        p0_valid = 1'b0;
        @(negedge clk);
        chk("t3_pend7_b", 32'(pend_mask[7]), 32'd1);
        @(negedge clk);
        chk("t3_pend7_c", 32'(pend_mask[7]), 32'd1);
        @(negedge clk);
        chk("t3_pend7_d", 32'(pend_mask[7]), 32'd0);
        chk("t3_count",  32'(wlog.size()), 32'd2);
        chk("t3_first",  ent(0), pack_ent(1'b1, 5'd7, 16'h1));
        chk("t3_last",   ent(1), pack_ent(1'b0, 5'd7, 16'h2));

        // 4: both ports streaming for 20 cycles
        tick();
        wlog.delete();
        n0 = 0; n1 = 0;
        p0_valid = 1'b1; p1_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            p0_addr = 5'(8 + (n0 % 8));  p0_data = 32'(32'h1000 + n0);
            p1_addr = 5'(16 + (n1 % 8)); p1_data = 32'(32'h2000 + n1);
            #1;
            hs0 = p0_ready; hs1 = p1_ready;
            tick();
            if (hs0) n0 = n0 + 1;
            if (hs1) n1 = n1 + 1;
        end
        p0_valid = 1'b0; p1_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("t4_p0_accepts", 32'(n0), 32'd10);
        chk("t4_p1_accepts", 32'(n1), 32'd11);
        chk("t4_writes", 32'(wlog.size()), 32'd21);
        bad_cyc = 0; bad_alt = 0; bad_dat = 0; k0 = 0; k1 = 0;
        foreach (wlog[i]) begin
            if (i > 0 && wlog[i].cyc != wlog[i-1].cyc + 1) bad_cyc++;
            if (wlog[i].src != ((i % 2) == 0)) bad_alt++;
            if (wlog[i].src == 1'b0) begin
                if (wlog[i].data != 32'(32'h1000 + k0) || wlog[i].addr != 5'(8 + (k0 % 8))) bad_dat++;
                k0++;
            end else begin
                if (wlog[i].data != 32'(32'h2000 + k1) || wlog[i].addr != 5'(16 + (k1 % 8))) bad_dat++;
                k1++;
            end
        end
        chk("t4_gaps", 32'(bad_cyc), 32'd0);
        chk("t4_alternate", 32'(bad_alt), 32'd0);
        chk("t4_data_order", 32'(bad_dat), 32'd0);

        // 5: write to r0 is accepted and dropped
        tick();
        wlog.delete();
        p0_valid = 1'b1; p0_addr = 5'd0; p0_data = 32'h0000_FFFF;
        #1;
        chk("t5_p0_rdy", 32'(p0_ready), 32'd1);
        tick();
        p0_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t5_wr_en", 32'(wr_en), 32'd0);
            chk("t5_pend0", 32'(pend_mask[0]), 32'd0);
        end
        chk("t5_drained", 32'(p0_ready), 32'd1);
        chk("t5_count", 32'(wlog.size()), 32'd0);

        // 6: asynchronous reset with both slots full and a write in the output stage
        tick();
        p0_valid = 1'b1; p0_addr = 5'd9;  p0_data = 32'h99;
        p1_valid = 1'b1; p1_addr = 5'd10; p1_data = 32'hA0;
        tick();
        p0_valid = 1'b0;
        p1_addr = 5'd11; p1_data = 32'hB0;
        tick();
        p1_valid = 1'b0;
        #2;
        chk("t6_pre_wr_en", 32'(wr_en), 32'd1);
        chk("t6_pre_pend", pend_mask, 32'h0000_0E00);
        rst_n = 1'b0;
        #1;
        chk("t6_wr_en",   32'(wr_en),   32'd0);
        chk("t6_wr_addr", 32'(wr_addr), 32'd0);
        chk("t6_wr_data", wr_data,      32'd0);
        chk("t6_wr_src",  32'(wr_src),  32'd0);
        chk("t6_pend",    pend_mask,    32'd0);
        chk("t6_p0_rdy",  32'(p0_ready), 32'd1);
        chk("t6_p1_rdy",  32'(p1_ready), 32'd1);
        wlog.delete();
        tick();
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("t6_no_write", 32'(wlog.size()), 32'd0);
        chk("t6_pend_idle", pend_mask, 32'd0);
        tick();
        p1_valid = 1'b1; p1_addr = 5'd12; p1_data = 32'hC0;
        tick();
        p1_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6_new_count", 32'(wlog.size()), 32'd1);
        chk("t6_new_write", ent(0), pack_ent(1'b1, 5'd12, 16'hC0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
